// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: plays the codec init table over a bit-banged 2-wire
// bus after reset, then forwards single host register writes.
// Optional build macro: CODEC_CFG_RETRY_EN (re-send a NACKed word up to
// MAX_RETRY times before flagging error). Without it a NACK flags error and
// the sequencer moves on to the next word.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// INIT_LOAD | load device byte + init table word idx into the shifter
// IDLE      | init complete, bus released, waiting for a host request
// START     | SDA low while SCL high, then SCL low
// BIT       | one data bit, MSB first, 4 quarter periods
// ACK       | release SDA, clock the ninth bit, sample ACK/NACK
// STOP      | SDA low, SCL high, SDA released
// GAP       | bus idle for GAP_QTRS quarter periods, then pick next word
module codec_cfg_sequencer #(
    parameter int unsigned CLK_DIV   = 125,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP_QTRS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [15:0] req_word,
    output logic        req_ready,
    output logic        init_done,
    output logic        busy,
    output logic        error,
    output logic        i2c_sclk,
    output logic        sdat_oe,
    input  logic        sdat_in
);

    typedef enum logic [2:0] {
        S_INIT_LOAD,
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP
    } state_t;

    localparam int unsigned INIT_LEN = 9;
    localparam logic [3:0]  IDX_LAST = 4'(INIT_LEN - 1);
    localparam logic [7:0]  DEV_BYTE = {DEV_ADDR, 1'b0};
    localparam logic [9:0]  DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_QTRS - 1);
`ifdef CODEC_CFG_RETRY_EN
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);
`else
    // No re-sends: the limit is forced to zero whatever MAX_RETRY says.
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY) & 8'h00;
`endif

    state_t      state_q, state_d;
    logic [9:0]  div_cnt_q, div_cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [15:0] word_q, word_d;
    logic        nack_q, nack_d;
    logic        sclk_q, sclk_d;
    logic        oe_q, oe_d;
    logic        init_done_q, init_done_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        sdat_meta_q, sdat_sync_q;

    logic        qtick;
    logic        retry_left;
    logic [15:0] init_word;

    assign req_ready = ready_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign i2c_sclk  = sclk_q;
    assign sdat_oe   = oe_q;

    assign qtick      = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
    assign retry_left = (retry_cnt_q != RETRY_LIMIT);

    // Quarter-period divider: free-runs outside IDLE, parked at zero in IDLE.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 10'd1;
        end
    end

    // Codec bring-up sequence: reset, power on, then path/format setup, activate.
    always_comb begin
        init_word = 16'h1E00;
        case (idx_q)
            4'd0:    init_word = 16'h1E00;
            4'd1:    init_word = 16'h0C00;
            4'd2:    init_word = 16'h0812;
            4'd3:    init_word = 16'h0A00;
            4'd4:    init_word = 16'h0E02;
            4'd5:    init_word = 16'h1000;
            4'd6:    init_word = 16'h0017;
            4'd7:    init_word = 16'h0217;
            4'd8:    init_word = 16'h1201;
            default: init_word = 16'h1E00;
        endcase
    end

    // Next-state and bus-pin logic; every bus step waits for qtick.
    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        idx_d       = idx_q;
        retry_cnt_d = retry_cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        nack_d      = nack_q;
        sclk_d      = sclk_q;
        oe_d        = oe_q;
        init_done_d = init_done_q;
        error_d     = error_q;

        case (state_q)
            S_INIT_LOAD: begin
                word_d     = init_word;
                shift_d    = {DEV_BYTE, init_word};
                qtr_d      = 2'd0;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 2'd0;
                nack_d     = 1'b0;
                state_d    = S_START;
            end
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    word_d     = req_word;
                    shift_d    = {DEV_BYTE, req_word};
                    qtr_d      = 2'd0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 2'd0;
                    nack_d     = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0:    oe_d = 1'b1;
                        2'd2:    sclk_d = 1'b0;
                        2'd3:    state_d = S_BIT;
                        default: ;
                    endcase
                end
            end
            S_BIT: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0:    oe_d = ~shift_q[23];
                        2'd1:    sclk_d = 1'b1;
                        2'd3: begin
                            sclk_d    = 1'b0;
                            shift_d   = {shift_q[22:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_d = S_ACK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ACK: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0:    oe_d = 1'b0;
                        2'd1:    sclk_d = 1'b1;
                        2'd2: begin
                            nack_d = sdat_sync_q;
                            // Final failure of this word: no re-send left.
                            if (sdat_sync_q && !retry_left) begin
                                error_d = 1'b1;
                            end
                        end
                        2'd3: begin
                            sclk_d = 1'b0;
                            if (nack_q || (byte_cnt_q == 2'd2)) begin
                                state_d = S_STOP;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                                state_d    = S_BIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STOP: begin
                if (qtick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0:    oe_d = 1'b1;
                        2'd1:    sclk_d = 1'b1;
                        2'd2:    oe_d = 1'b0;
                        2'd3: begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end
                        default: ;
                    endcase
                end
            end
            S_GAP: begin
                if (qtick) begin
                    if (gap_cnt_q != GAP_LAST) begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end else if (nack_q && retry_left) begin
                        retry_cnt_d = retry_cnt_q + 8'd1;
                        shift_d     = {DEV_BYTE, word_q};
                        qtr_d       = 2'd0;
                        bit_cnt_d   = 3'd0;
                        byte_cnt_d  = 2'd0;
                        nack_d      = 1'b0;
                        state_d     = S_START;
                    end else begin
                        retry_cnt_d = '0;
                        if (!init_done_q) begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == IDX_LAST) begin
                                init_done_d = 1'b1;
                                state_d     = S_IDLE;
                            end else begin
                                state_d = S_INIT_LOAD;
                            end
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_INIT_LOAD;
        endcase

        // Registered so both read 0 while reset is held.
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE) && init_done_d;
    end

    // State and datapath registers; reset releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT_LOAD;
            div_cnt_q   <= '0;
            qtr_q       <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            retry_cnt_q <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            nack_q      <= 1'b0;
            sclk_q      <= 1'b1;
            oe_q        <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            qtr_q       <= qtr_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            retry_cnt_q <= retry_cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            nack_q      <= nack_d;
            sclk_q      <= sclk_d;
            oe_q        <= oe_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    // Two-flop synchroniser for the SDAT pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdat_meta_q <= 1'b1;
            sdat_sync_q <= 1'b1;
        end else begin
            sdat_meta_q <= sdat_in;
            sdat_sync_q <= sdat_meta_q;
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural codec model on
// the 2-wire bus. Honours CODEC_CFG_RETRY_EN when choosing expectations.
module tb_codec_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_word = 16'h0000;
    logic        req_ready, init_done, busy, error, i2c_sclk, sdat_oe;

    logic m_drive = 1'b0;
    wire  sda_line = ~(sdat_oe | m_drive);

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] INIT_TBL [0:8] = '{16'h1E00, 16'h0C00, 16'h0812,
        16'h0A00, 16'h0E02, 16'h1000, 16'h0017, 16'h0217, 16'h1201};

    codec_cfg_sequencer #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_word(req_word),
        .req_ready(req_ready), .init_done(init_done), .busy(busy), .error(error),
        .i2c_sclk(i2c_sclk), .sdat_oe(sdat_oe), .sdat_in(sda_line)
    );

    always #5 clk = ~clk;

    // Codec model: 0 = ACK all, 1 = NACK device byte of transaction m_target once, 2 = NACK all
    int          m_mode = 0;
    int          m_target = 0;
    int          m_start_cnt = 0;
    int          m_txn_cnt = 0;
    int          m_bit_cnt = 0;
    int          m_byte_idx = 0;
    int          m_nb = 0;
    logic [7:0]  m_sh = 8'h00;
    logic [23:0] m_val = 24'h0;
    logic        m_in_txn = 1'b0;
    logic        m_ack_ph = 1'b0;
    logic        m_scl_p = 1'b1;
    logic        m_sda_p = 1'b1;
    logic [23:0] log_val [0:63];
    int          log_n [0:63];

    always @(negedge clk) begin
        logic scl_now, sda_now, nack_now;
        scl_now = i2c_sclk;
        sda_now = sda_line;
        if (reset) begin
            m_drive = 1'b0; m_in_txn = 1'b0; m_ack_ph = 1'b0;
            m_bit_cnt = 0; m_byte_idx = 0; m_start_cnt = 0; m_txn_cnt = 0;
        end else if (m_scl_p && scl_now && m_sda_p && !sda_now) begin
            m_start_cnt++; m_in_txn = 1'b1; m_bit_cnt = 0; m_byte_idx = 0;
            m_val = 24'h0; m_nb = 0; m_ack_ph = 1'b0;
        end else if (m_scl_p && scl_now && !m_sda_p && sda_now) begin
            if (m_in_txn && m_txn_cnt < 64) begin
                log_val[m_txn_cnt] = m_val;
                log_n[m_txn_cnt] = m_nb;
                m_txn_cnt++;
            end
            m_in_txn = 1'b0;
        end else if (m_in_txn && !m_scl_p && scl_now) begin
            if (!m_ack_ph && m_bit_cnt < 8) begin
                m_sh = {m_sh[6:0], sda_now};
                m_bit_cnt++;
            end
        end else if (m_in_txn && m_scl_p && !scl_now) begin
            if (m_ack_ph) begin
                m_ack_ph = 1'b0; m_drive = 1'b0;
                m_val = {m_val[15:0], m_sh}; m_nb++;
                m_bit_cnt = 0; m_byte_idx++;
            end else if (m_bit_cnt == 8) begin
                nack_now = (m_mode == 2) ||
                           (m_mode == 1 && m_start_cnt == m_target && m_byte_idx == 0);
                m_ack_ph = 1'b1;
                m_drive = ~nack_now;
            end
        end
        m_scl_p = scl_now;
        m_sda_p = sda_now;
    end

    task automatic pulse_reset(input int mode, input int target);
        @(negedge clk);
        reset = 1'b1; m_mode = mode; m_target = target;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_init(input int budget, input string tag);
        int cyc = 0;
        while (!init_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!init_done) begin
            n_bad++;
            $display("FAIL %s_init_timeout init_done=%0b after %0d cycles, want 1", tag, init_done, cyc);
        end
    endtask

    task automatic check_txn(input int i, input int want_n, input logic [23:0] want_v, input string tag);
        n_cmp++;
        if (log_n[i] !== want_n || log_val[i] !== want_v) begin
            n_bad++;
            $display("FAIL %s_txn[%0d] got n=%0d val=%h want n=%0d val=%h",
                     tag, i, log_n[i], log_val[i], want_n, want_v);
        end
    endtask

    task automatic check_bit(input logic got, input logic want, input string name);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0b want %0b", name, got, want);
        end
    endtask

    task automatic check_int(input int got, input int want, input string name);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_mode = 0;
        repeat (3) @(negedge clk);
        check_bit(i2c_sclk, 1'b1, "rst_sclk");
        check_bit(sdat_oe, 1'b0, "rst_oe");
        check_bit(req_ready, 1'b0, "rst_ready");
        check_bit(init_done, 1'b0, "rst_init_done");
        check_bit(busy, 1'b0, "rst_busy");
        check_bit(error, 1'b0, "rst_error");
    endtask

    task automatic test_init();
        reset = 1'b0;
        wait_init(8000, "init");
        check_int(m_txn_cnt, 9, "init_txn_count");
        for (int i = 0; i < 9; i++) check_txn(i, 3, {8'h34, INIT_TBL[i]}, "init");
        check_bit(error, 1'b0, "init_error");
        check_bit(busy, 1'b0, "init_busy");
        check_bit(req_ready, 1'b1, "init_ready");
    endtask

    task automatic test_runtime();
        int cyc = 0;
        @(negedge clk);
        req_word = 16'h0A06; req_valid = 1'b1;
        check_bit(req_ready, 1'b1, "rt_ready_before");
        @(posedge clk); #1;
        check_bit(req_ready, 1'b0, "rt_ready_after");
        check_bit(busy, 1'b1, "rt_busy_after");
        req_valid = 1'b0;
        @(negedge clk);
        while (busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        check_int(cyc, 496, "rt_busy_cycles");
        check_int(m_txn_cnt, 10, "rt_txn_count");
        check_txn(9, 3, 24'h340A06, "rt");
    endtask

    task automatic test_req_during_init();
        int cyc = 0;
        int viol = 0;
        pulse_reset(0, 0);
        req_word = 16'h1234; req_valid = 1'b1;
        while (!init_done && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (req_ready && !init_done) viol++;
        end
        check_bit(init_done, 1'b1, "rdi_init_done");
        check_int(viol, 0, "rdi_ready_during_init");
        check_int(m_txn_cnt, 9, "rdi_txn_count_at_done");
        check_txn(0, 3, 24'h341E00, "rdi");
        check_bit(req_ready, 1'b1, "rdi_ready_at_done");
        @(posedge clk); #1;
        check_bit(busy, 1'b1, "rdi_accept_busy");
        req_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_int(m_txn_cnt, 10, "rdi_txn_count_after");
        check_txn(9, 3, 24'h341234, "rdi");
    endtask

    task automatic test_nack_once();
        pulse_reset(1, 4);
        wait_init(9000, "n1");
        check_txn(3, 1, 24'h000034, "n1");
`ifdef CODEC_CFG_RETRY_EN
        check_int(m_txn_cnt, 10, "n1_txn_count");
        check_txn(4, 3, 24'h340A00, "n1");
        check_txn(5, 3, 24'h340E02, "n1");
        check_bit(error, 1'b0, "n1_error");
`else
        check_int(m_txn_cnt, 9, "n1_txn_count");
        check_txn(4, 3, 24'h340E02, "n1");
        check_txn(8, 3, 24'h341201, "n1");
        check_bit(error, 1'b1, "n1_error");
`endif
    endtask

    task automatic test_nack_all();
        int want;
`ifdef CODEC_CFG_RETRY_EN
        want = 36;
`else
        want = 9;
`endif
        pulse_reset(2, 0);
        wait_init(25000, "na");
        check_int(m_txn_cnt, want, "na_txn_count");
        check_txn(0, 1, 24'h000034, "na");
        check_txn(want - 1, 1, 24'h000034, "na");
        check_bit(error, 1'b1, "na_error");
        check_bit(init_done, 1'b1, "na_init_done");
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        pulse_reset(0, 0);
        while (!(m_start_cnt == 5 && m_byte_idx == 2 && m_bit_cnt >= 1 &&
                 i2c_sclk == 1'b0 && sdat_oe == 1'b1) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_int(m_start_cnt * 10 + m_byte_idx, 52, "rm_reached_word5_byte2");
        #1 reset = 1'b1;
        #1;
        check_bit(i2c_sclk, 1'b1, "rm_sclk_released");
        check_bit(sdat_oe, 1'b0, "rm_oe_released");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_init(8000, "rm");
        check_int(m_txn_cnt, 9, "rm_txn_count");
        check_txn(0, 3, 24'h341E00, "rm");
    endtask

    initial begin
        test_reset();
        test_init();
        test_runtime();
        test_req_during_init();
        test_nack_once();
        test_nack_all();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
